// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and constants for the alarm ring/snooze sequencer
package alarm_pkg;

    localparam int TIMER_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/rise_edge.sv
// rtl/rise_edge.sv - 0->1 detector on a level input, one delay flop plus AND
module rise_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_level_d;

    // Delay flop resets low so a level already high at reset release reads as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= i_level;
        end
    end

    assign o_rise = i_level & ~r_level_d;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// rtl/alarm_ring_ctrl.sv - ring/snooze/auto-stop sequencer driven by the alarm match level
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3,
    parameter int unsigned BEEP_HALF   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_alarm_en,
    input  logic       i_alarm_match,
    input  logic       i_stop_btn,
    input  logic       i_snooze_btn,
    output logic       o_buzzer,
    output logic       o_ringing,
    output logic       o_snoozing,
    output logic [2:0] o_snooze_cnt
);

    localparam logic [TIMER_W-1:0] RING_LAST   = TIMER_W'(RING_SECS - 1);
    localparam logic [TIMER_W-1:0] SNOOZE_LAST = TIMER_W'(SNOOZE_SECS - 1);
    localparam logic [7:0]         BEEP_LAST   = 8'(BEEP_HALF - 1);
    localparam logic [2:0]         MAX_CNT     = 3'(MAX_SNOOZE);

    logic               w_rise_match;
    logic               w_rise_stop;
    logic               w_rise_snooze;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic [7:0]         r_beep_cnt;
    logic [7:0]         w_beep_cnt_nxt;
    logic               r_phase;
    logic               w_phase_nxt;
    logic [2:0]         r_snooze_cnt;
    logic [2:0]         w_snooze_cnt_nxt;
    logic               r_buzzer;
    logic               r_ringing;
    logic               r_snoozing;

    rise_edge u_rise_match (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (i_alarm_match),
        .o_rise  (w_rise_match)
    );

    rise_edge u_rise_stop (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (i_stop_btn),
        .o_rise  (w_rise_stop)
    );

    rise_edge u_rise_snooze (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (i_snooze_btn),
        .o_rise  (w_rise_snooze)
    );

    // State, timer, beep and snooze counters; outputs registered from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_beep_cnt   <= '0;
            r_phase      <= 1'b0;
            r_snooze_cnt <= '0;
            r_buzzer     <= 1'b0;
            r_ringing    <= 1'b0;
            r_snoozing   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_beep_cnt   <= w_beep_cnt_nxt;
            r_phase      <= w_phase_nxt;
            r_snooze_cnt <= w_snooze_cnt_nxt;
            r_buzzer     <= (w_state_nxt == RING) & w_phase_nxt;
            r_ringing    <= (w_state_nxt == RING);
            r_snoozing   <= (w_state_nxt == SNOOZE);
        end
    end

    // Next-state logic; disarming wins over stop, stop over snooze, snooze over timeout.
    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = r_timer;
        w_beep_cnt_nxt   = r_beep_cnt;
        w_phase_nxt      = r_phase;
        w_snooze_cnt_nxt = r_snooze_cnt;

        if (!i_alarm_en) begin
            w_state_nxt      = IDLE;
            w_timer_nxt      = '0;
            w_snooze_cnt_nxt = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_rise_match) begin
                        w_state_nxt      = RING;
                        w_timer_nxt      = '0;
                        w_snooze_cnt_nxt = '0;
                        w_beep_cnt_nxt   = '0;
                        w_phase_nxt      = 1'b1;
                    end
                end
                RING: begin
                    if (w_rise_stop) begin
                        w_state_nxt = DONE;
                    end else if (w_rise_snooze && (r_snooze_cnt < MAX_CNT)) begin
                        w_state_nxt      = SNOOZE;
                        w_snooze_cnt_nxt = r_snooze_cnt + 3'd1;
                        w_timer_nxt      = '0;
                    end else if (r_timer == RING_LAST) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_timer_nxt = r_timer + TIMER_W'(1);
                        if (r_beep_cnt == BEEP_LAST) begin
                            w_beep_cnt_nxt = '0;
                            w_phase_nxt    = ~r_phase;
                        end else begin
                            w_beep_cnt_nxt = r_beep_cnt + 8'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (w_rise_stop) begin
                        w_state_nxt = DONE;
                    end else if (r_timer == SNOOZE_LAST) begin
                        w_state_nxt    = RING;
                        w_timer_nxt    = '0;
                        w_beep_cnt_nxt = '0;
                        w_phase_nxt    = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + TIMER_W'(1);
                    end
                end
                DONE: begin
                    // Wait out the current match minute so it cannot re-trigger.
                    if (!i_alarm_match) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign o_buzzer     = r_buzzer;
    assign o_ringing    = r_ringing;
    assign o_snoozing   = r_snoozing;
    assign o_snooze_cnt = r_snooze_cnt;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb/tb_alarm_ring_ctrl.sv - self-checking bench for alarm_ring_ctrl
module tb_alarm_ring_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alarm_en, alarm_match, stop_btn, snooze_btn;
    logic       buz0, ring0, snz0;
    logic [2:0] cnt0;
    logic       buz1, ring1, snz1;
    logic [2:0] cnt1;

    int total = 0;
    int bad   = 0;

    // Model configuration per instance: index 0 = directed config, index 1 = alternate config.
    int P_RING [2] = '{8, 7};
    int P_SNZ  [2] = '{5, 4};
    int P_MAX  [2] = '{2, 3};
    int P_BEEP [2] = '{1, 3};

    // Model state: 0 idle, 1 ringing, 2 snoozing, 3 done.
    int m_st   [2];
    int m_left [2];
    int m_age  [2];
    int m_cnt  [2];
    bit p_match, p_stop, p_snz;

    always #5 clk = ~clk;

    alarm_ring_ctrl #(
        .RING_SECS(8), .SNOOZE_SECS(5), .MAX_SNOOZE(2), .BEEP_HALF(1)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_alarm_en(alarm_en), .i_alarm_match(alarm_match),
        .i_stop_btn(stop_btn), .i_snooze_btn(snooze_btn),
        .o_buzzer(buz0), .o_ringing(ring0), .o_snoozing(snz0), .o_snooze_cnt(cnt0)
    );

    alarm_ring_ctrl #(
        .RING_SECS(7), .SNOOZE_SECS(4), .MAX_SNOOZE(3), .BEEP_HALF(3)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_alarm_en(alarm_en), .i_alarm_match(alarm_match),
        .i_stop_btn(stop_btn), .i_snooze_btn(snooze_btn),
        .o_buzzer(buz1), .o_ringing(ring1), .o_snoozing(snz1), .o_snooze_cnt(cnt1)
    );

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_st[m] = 0; m_left[m] = 0; m_age[m] = 0; m_cnt[m] = 0;
        end
        p_match = 0; p_stop = 0; p_snz = 0;
    endtask

    // Behaviour described as remaining-time countdowns and time-since-ring-start.
    task automatic model_step();
        bit rm, rs, rz;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rm = alarm_match && !p_match;
        rs = stop_btn && !p_stop;
        rz = snooze_btn && !p_snz;
        p_match = alarm_match; p_stop = stop_btn; p_snz = snooze_btn;
        for (int m = 0; m < 2; m++) begin
            if (!alarm_en) begin
                m_st[m] = 0; m_cnt[m] = 0;
            end else begin
                case (m_st[m])
                    0: if (rm) begin
                        m_st[m] = 1; m_left[m] = P_RING[m]; m_age[m] = 0; m_cnt[m] = 0;
                    end
                    1: if (rs) m_st[m] = 3;
                       else if (rz && m_cnt[m] < P_MAX[m]) begin
                           m_st[m] = 2; m_cnt[m]++; m_left[m] = P_SNZ[m];
                       end else if (m_left[m] == 1) m_st[m] = 3;
                       else begin
                           m_left[m]--; m_age[m]++;
                       end
                    2: if (rs) m_st[m] = 3;
                       else if (m_left[m] == 1) begin
                           m_st[m] = 1; m_left[m] = P_RING[m]; m_age[m] = 0;
                       end else m_left[m]--;
                    default: if (!alarm_match) m_st[m] = 0;
                endcase
            end
        end
    endtask

    function automatic logic exp_buz(int m);
        return (m_st[m] == 1) && (((m_age[m] / P_BEEP[m]) % 2) == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        alarm_match = 0; stop_btn = 0; snooze_btn = 0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 0;
        alarm_en = 1'($urandom); alarm_match = 1'($urandom);
        stop_btn = 1'($urandom); snooze_btn = 1'($urandom);
        model_reset();
        tick(); tick();
        total++;
        if ({buz0, ring0, snz0, cnt0, buz1, ring1, snz1, cnt1} !== 12'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0", {buz0, ring0, snz0, cnt0, buz1, ring1, snz1, cnt1});
        end
        alarm_match = 0;
        #2 rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({buz0, ring0, snz0, cnt0} !== 6'd0) begin
                bad++;
                $display("FAIL release_idle[%0d]: got %b want 0", i, {buz0, ring0, snz0, cnt0});
            end
        end
        idle_inputs();
    endtask

    task automatic test_ring_timeout();
        int n;
        alarm_en = 1;
        alarm_match = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (ring0 !== 1'b1 || buz0 !== ((i % 2) == 0)) begin
                bad++;
                $display("FAIL ring_cycle[%0d]: got ring=%b buz=%b want ring=1 buz=%b", i, ring0, buz0, (i % 2) == 0);
            end
        end
        tick();
        total++;
        if (ring0 !== 1'b0 || buz0 !== 1'b0) begin
            bad++;
            $display("FAIL ring_timeout: got ring=%b buz=%b want 0 0", ring0, buz0);
        end
        tick();
        total++;
        if (ring0 !== 1'b0) begin
            bad++;
            $display("FAIL done_no_retrigger: got ring=%b want 0", ring0);
        end
        alarm_match = 0;
        tick();
        alarm_match = 1;
        tick();
        total++;
        if (ring0 !== 1'b1 || buz0 !== 1'b1) begin
            bad++;
            $display("FAIL ring_again: got ring=%b buz=%b want 1 1", ring0, buz0);
        end
        n = 1;
        while (ring0 === 1'b1 && n < 20) begin
            tick();
            if (ring0 === 1'b1) n++;
        end
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL ring_again_len: got %0d want 8", n);
        end
        idle_inputs();
    endtask

    task automatic snooze_cycle(input int want_cnt);
        snooze_btn = 1;
        tick();
        snooze_btn = 0;
        total++;
        if (snz0 !== 1'b1 || ring0 !== 1'b0 || cnt0 !== 3'(want_cnt)) begin
            bad++;
            $display("FAIL snooze_enter: got snz=%b ring=%b cnt=%0d want 1 0 %0d", snz0, ring0, cnt0, want_cnt);
        end
        for (int i = 1; i < 5; i++) begin
            tick();
            total++;
            if (snz0 !== 1'b1) begin
                bad++;
                $display("FAIL snooze_hold[%0d]: got %b want 1", i, snz0);
            end
        end
        tick();
        total++;
        if (snz0 !== 1'b0 || ring0 !== 1'b1 || buz0 !== 1'b1) begin
            bad++;
            $display("FAIL snooze_return: got snz=%b ring=%b buz=%b want 0 1 1", snz0, ring0, buz0);
        end
    endtask

    task automatic test_snooze();
        int n;
        alarm_en = 1;
        alarm_match = 1;
        tick(); tick(); tick();
        snooze_cycle(1);
        snooze_cycle(2);
        snooze_btn = 1;
        tick();
        snooze_btn = 0;
        total++;
        if (ring0 !== 1'b1 || snz0 !== 1'b0 || cnt0 !== 3'd2) begin
            bad++;
            $display("FAIL snooze_exhausted: got ring=%b snz=%b cnt=%0d want 1 0 2", ring0, snz0, cnt0);
        end
        n = 0;
        while (ring0 === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n != 7 || cnt0 !== 3'd2) begin
            bad++;
            $display("FAIL snooze_exhausted_timeout: got ticks=%0d cnt=%0d want 7 2", n, cnt0);
        end
        idle_inputs();
    endtask

    task automatic test_stop_and_snooze();
        alarm_en = 1;
        alarm_match = 1;
        tick(); tick();
        snooze_cycle(1);
        tick();
        stop_btn = 1; snooze_btn = 1;
        tick();
        total++;
        if (ring0 !== 1'b0 || snz0 !== 1'b0 || buz0 !== 1'b0 || cnt0 !== 3'd1) begin
            bad++;
            $display("FAIL stop_wins: got ring=%b snz=%b buz=%b cnt=%0d want 0 0 0 1", ring0, snz0, buz0, cnt0);
        end
        idle_inputs();
    endtask

    task automatic test_disarm();
        alarm_en = 1;
        alarm_match = 1;
        tick(); tick();
        snooze_btn = 1;
        tick();
        snooze_btn = 0;
        tick(); tick();
        alarm_en = 0;
        tick();
        total++;
        if (snz0 !== 1'b0 || ring0 !== 1'b0 || cnt0 !== 3'd0) begin
            bad++;
            $display("FAIL disarm: got snz=%b ring=%b cnt=%0d want 0 0 0", snz0, ring0, cnt0);
        end
        alarm_match = 0;
        tick();
        alarm_match = 1;
        tick(); tick();
        total++;
        if (ring0 !== 1'b0) begin
            bad++;
            $display("FAIL disarmed_match: got ring=%b want 0", ring0);
        end
        alarm_en = 1;
        tick(); tick(); tick();
        total++;
        if (ring0 !== 1'b0 || snz0 !== 1'b0) begin
            bad++;
            $display("FAIL arm_during_match: got ring=%b snz=%b want 0 0", ring0, snz0);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        alarm_en = 1;
        alarm_match = 1;
        tick(); tick(); tick();
        #2 rst_n = 0;
        model_reset();
        #1;
        total++;
        if ({buz0, ring0, snz0, cnt0} !== 6'd0) begin
            bad++;
            $display("FAIL async_reset: got %b want 0", {buz0, ring0, snz0, cnt0});
        end
        tick();
        #2 rst_n = 1;
        tick();
        total++;
        if (ring0 !== 1'b1 || buz0 !== 1'b1) begin
            bad++;
            $display("FAIL held_match_after_reset: got ring=%b buz=%b want 1 1", ring0, buz0);
        end
        alarm_en = 0;
        idle_inputs();
    endtask

    task automatic test_random();
        logic gb, gr, gs;
        logic [2:0] gc;
        for (int c = 0; c < 3000; c++) begin
            rst_n       = ($urandom_range(0, 399) != 0);
            alarm_en    = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 11) == 0) alarm_match = ~alarm_match;
            stop_btn    = ($urandom_range(0, 9) == 0);
            snooze_btn  = ($urandom_range(0, 3) == 0);
            tick();
            for (int m = 0; m < 2; m++) begin
                gb = (m == 0) ? buz0 : buz1;
                gr = (m == 0) ? ring0 : ring1;
                gs = (m == 0) ? snz0 : snz1;
                gc = (m == 0) ? cnt0 : cnt1;
                total++;
                if (gb !== exp_buz(m) || gr !== (m_st[m] == 1) || gs !== (m_st[m] == 2) || gc !== 3'(m_cnt[m])) begin
                    bad++;
                    $display("FAIL random[%0d] dut%0d: got buz=%b ring=%b snz=%b cnt=%0d want %b %b %b %0d",
                             c, m, gb, gr, gs, gc, exp_buz(m), m_st[m] == 1, m_st[m] == 2, m_cnt[m]);
                end
            end
        end
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_ring_timeout();
        test_snooze();
        test_stop_and_snooze();
        test_disarm();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_ring_ctrl.md
# alarm_ring_ctrl

Ring/snooze sequencer that sits downstream of the alarm clock datapath. It turns the clock's level-type alarm-match output into a user-facing alarm: it drives a beeping buzzer, supports a bounded number of snoozes, and auto-stops after a timeout. One clk cycle equals one clock second, matching the datapath's seconds counter. The block reads only the match level and user buttons; it never writes clock or alarm time.

## Interface
- RING_SECS, 60: ring duration before auto-stop, in cycles; 1..65535
- SNOOZE_SECS, 300: snooze duration, in cycles; 1..65535
- MAX_SNOOZE, 3: snoozes allowed per alarm event; 0..7
- BEEP_HALF, 1: buzzer half-period, in cycles; 1..255
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- alarm_en  in  1  alarm armed (level)
- alarm_match  in  1  high while clock time equals alarm time (level, about one minute long)
- stop_btn  in  1  raw level; action on 0->1
- snooze_btn  in  1  raw level; action on 0->1
- buzzer  out  1  beep drive
- ringing  out  1  state == RING
- snoozing  out  1  state == SNOOZE
- snooze_cnt  out  3  snoozes used in the current event

## Operation
- Rising edges: rise = x & ~x_d, where x_d is a flop that resets to 0.
  - A level that is already high at reset release therefore counts as an edge.
- Four states, all outputs registered:
  - IDLE: alarm_en & rise(match) -> RING. Clear timer, snooze_cnt and beep counter; set phase = 1.
  - RING:
    - rise(stop) -> DONE.
    - Else rise(snooze) with snooze_cnt < MAX_SNOOZE -> SNOOZE; snooze_cnt++ and timer cleared.
    - Else timer == RING_SECS-1 -> DONE.
    - Otherwise timer++.
    - rise(snooze) with snooze_cnt == MAX_SNOOZE is ignored.
  - SNOOZE:
    - rise(stop) -> DONE.
    - timer == SNOOZE_SECS-1 -> RING; timer cleared, beep restarts with phase = 1.
    - Otherwise timer++.
  - DONE: ~alarm_match -> IDLE. Prevents a re-trigger inside the same match minute.
- alarm_en low in any state -> IDLE on the next edge, and snooze_cnt cleared. This overrides every other transition.
- Priority: !alarm_en > stop > snooze > timeout.
- rise(match) in RING, SNOOZE or DONE is ignored.
- Buzzer:
  - In RING only, buzzer = phase.
  - The beep counter runs 0..BEEP_HALF-1; phase toggles on wrap.
  - Outside RING, buzzer = 0.
- Timer: 16-bit unsigned; it never exceeds max(RING_SECS, SNOOZE_SECS) - 1.

## Timing
- Reset values: buzzer 0, ringing 0, snoozing 0, snooze_cnt 0. Internally: state IDLE, timer 0, edge flops 0.
- Assertion of rst_n is asynchronous: outputs clear immediately, including mid-RING or mid-SNOOZE.
- Latency: an input edge sampled at clock edge k gives the new state and outputs after edge k (visible in cycle k+1). There is no further latency.
- ringing stays high for exactly RING_SECS cycles when no button is pressed.
- snoozing stays high for exactly SNOOZE_SECS cycles.
- Buzzer pattern after RING entry: BEEP_HALF cycles high, BEEP_HALF cycles low, repeating.
- Buttons need no handshake. Each 0->1 transition is one request; holding the button does not repeat it.

## Structure
- Package alarm_pkg holds:
  - the state enum: IDLE=2'd0, RING=2'd1, SNOOZE=2'd2, DONE=2'd3
  - the 16-bit timer width constant
- Sub-module rise_edge (one flop plus AND): instantiate three times, for match, stop and snooze.
- The FSM, timer and beep counter live in the top module.

## Test plan
Parameters for scenarios 2-6: RING_SECS=8, SNOOZE_SECS=5, MAX_SNOOZE=2, BEEP_HALF=1.
1. Apply reset with random inputs -> all outputs 0. Release with match=0 -> outputs stay 0.
2. alarm_en=1, match 0->1 at edge k and held high -> ringing=1 for cycles k+1..k+8, buzzer 1,0,1,0,1,0,1,0, then DONE with ringing 0. Drop match -> IDLE. A new match rise rings again.
3. Snooze in the 3rd ring cycle -> snoozing=1 for 5 cycles, snooze_cnt=1, then ring restarts with buzzer=1. Second snooze -> cnt=2. Third snooze -> ignored; ringing continues to timeout and cnt stays 2.
4. stop and snooze rising in the same RING cycle -> DONE, snooze_cnt unchanged, buzzer 0 next cycle.
5. alarm_en dropped mid-SNOOZE -> IDLE next cycle and snooze_cnt=0. Match rise with alarm_en=0 -> no ring. alarm_en raised while match is already high -> no ring.
6. rst_n asserted mid-RING with match held high -> outputs 0 immediately. After release, alarm_en=1 -> ringing=1 one cycle later, because the reset edge flop makes the held match count as an edge.
